instr_loader: RTL and testbench

- Upstream stage of the multicycle RV32 core; owns the instruction memory.
- Before execution, receives the program as a byte stream over a valid/ready handshake and assembles little-endian 32-bit words into instruction memory.
- Holds the core in reset while loading, then releases it.
- Serves instruction fetches by PC. An all-zero word terminates the program, matching the core's halt-on-zero-instruction rule.

---
 rtl/instr_loader.sv | 154 +++++++++++++++
 tb/tb_instr_loader.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_loader.sv
// Instruction memory front end: assembles a little-endian byte stream into
// 32-bit words, holds the core in reset while loading, then serves fetches.
module instr_loader #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_byte,
    output logic              in_ready,
    input  logic [31:0]       fetch_addr,
    output logic [31:0]       fetch_instr,
    output logic              core_rst,
    output logic              load_done,
    output logic              overflow_err,
    output logic [ADDR_W:0]   word_count
);

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_DONE = 2'd1,
        S_ERR  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [23:0]       asm_q, asm_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [31:0]       fetch_q, fetch_d;
    logic              core_rst_q, core_rst_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [31:0]       mem_q [DEPTH];

    logic              accept;
    logic              word_done;
    logic [31:0]       wr_word;
    logic [ADDR_W-1:0] rd_idx;
    logic              rd_oob;
    logic              unused_addr_bits;

    assign in_ready  = (state_q == S_LOAD);
    assign accept    = in_valid && in_ready;
    assign word_done = accept && (byte_idx_q == 2'd3);
    assign wr_word   = {in_byte, asm_q};

    assign rd_idx = fetch_addr[ADDR_W+1:2];
    // Anything at or beyond DEPTH*4 reads as zero, i.e. halt.
    assign rd_oob = |fetch_addr[31:ADDR_W+2];
    assign unused_addr_bits = ^fetch_addr[1:0];

    always_comb begin
        byte_idx_d = byte_idx_q;
        asm_d      = asm_q;
        wr_ptr_d   = wr_ptr_q;
        cnt_d      = cnt_q;
        if (accept) begin
            byte_idx_d = byte_idx_q + 2'd1;
            unique case (byte_idx_q)
                2'd0:    asm_d[7:0]   = in_byte;
                2'd1:    asm_d[15:8]  = in_byte;
                2'd2:    asm_d[23:16] = in_byte;
                default: asm_d        = '0;
            endcase
        end
        if (word_done) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (cnt_q != (ADDR_W+1)'(DEPTH)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        fetch_d = rd_oob ? 32'h0 : mem_q[rd_idx];
    end

    // State register plus all datapath state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_LOAD;
            byte_idx_q <= '0;
            asm_q      <= '0;
            wr_ptr_q   <= '0;
            cnt_q      <= '0;
            fetch_q    <= '0;
            core_rst_q <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            asm_q      <= asm_d;
            wr_ptr_q   <= wr_ptr_d;
            cnt_q      <= cnt_d;
            fetch_q    <= fetch_d;
            core_rst_q <= core_rst_d;
            done_q     <= done_d;
            err_q      <= err_d;
            if (word_done) begin
                mem_q[wr_ptr_q] <= wr_word;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_LOAD: begin
                if (word_done) begin
                    if (wr_word == 32'h0) begin
                        state_d = S_DONE;
                    end else if (wr_ptr_q == ADDR_W'(DEPTH-1)) begin
                        state_d = S_ERR;
                    end
                end
            end
            S_DONE:  state_d = S_DONE;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_LOAD;
        endcase
    end

    // Outputs decode the next state so the registers match state_q.
    always_comb begin
        core_rst_d = 1'b1;
        done_d     = 1'b0;
        err_d      = 1'b0;
        unique case (state_d)
            S_DONE: begin
                core_rst_d = 1'b0;
                done_d     = 1'b1;
            end
            S_ERR: begin
                err_d = 1'b1;
            end
            default: begin
                core_rst_d = 1'b1;
            end
        endcase
    end

    assign fetch_instr  = fetch_q;
    assign core_rst     = core_rst_q;
    assign load_done    = done_q;
    assign overflow_err = err_q;
    assign word_count   = cnt_q;

endmodule

// File: tb/tb_instr_loader.sv
// Bench for instr_loader: byte-stream model checked every cycle,
// plus literal expectations for the directed scenarios.
module tb_instr_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_byte = 8'h00;
    logic        in_ready;
    logic [31:0] fetch_addr = 32'h0;
    logic [31:0] fetch_instr;
    logic        core_rst;
    logic        load_done;
    logic        overflow_err;
    logic [5:0]  word_count;

    int pass_cnt = 0;
    int total_cnt = 0;
    bit cmp_en = 1'b0;

    instr_loader #(.DEPTH(32), .ADDR_W(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_byte      (in_byte),
        .in_ready     (in_ready),
        .fetch_addr   (fetch_addr),
        .fetch_instr  (fetch_instr),
        .core_rst     (core_rst),
        .load_done    (load_done),
        .overflow_err (overflow_err),
        .word_count   (word_count)
    );

    always #5 clk = ~clk;

    // Model: program is a list of words built from a byte list.
    logic [31:0] m_mem [32];
    logic [7:0]  m_bytes [$];
    int          m_words;
    int          m_mode;
    logic [31:0] m_fetch;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) m_mem[i] = 32'h0;
            m_bytes.delete();
            m_words = 0;
            m_mode  = 0;
            m_fetch = 32'h0;
        end else begin
            if (fetch_addr >= 32'd128) m_fetch = 32'h0;
            else m_fetch = m_mem[fetch_addr / 4];
            if (m_mode == 0 && in_valid) begin
                m_bytes.push_back(in_byte);
                if (m_bytes.size() == 4) begin
                    logic [31:0] w;
                    w = 32'(m_bytes[0]) + (32'(m_bytes[1]) << 8)
                      + (32'(m_bytes[2]) << 16) + (32'(m_bytes[3]) << 24);
                    m_mem[m_words] = w;
                    m_words++;
                    m_bytes.delete();
                    if (w == 32'h0) m_mode = 1;
                    else if (m_words == 32) m_mode = 2;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end else begin
            pass_cnt++;
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc_in_ready", 32'(in_ready), 32'(m_mode == 0));
            check("cyc_core_rst", 32'(core_rst), 32'(m_mode != 1));
            check("cyc_load_done", 32'(load_done), 32'(m_mode == 1));
            check("cyc_overflow", 32'(overflow_err), 32'(m_mode == 2));
            check("cyc_word_count", 32'(word_count), 32'(m_words));
            check("cyc_fetch", fetch_instr, m_fetch);
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        in_valid = 1'b1;
        in_byte  = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic fetch(input logic [31:0] a);
        fetch_addr = a;
        @(posedge clk); #1;
    endtask

    logic [7:0] prog1 [8] = '{8'h13, 8'h05, 8'h50, 8'h00,
                              8'h00, 8'h00, 8'h00, 8'h00};

    initial begin
        do_reset();
        cmp_en = 1'b1;
        check("rst_core_rst", 32'(core_rst), 32'd1);
        check("rst_word_count", 32'(word_count), 32'd0);
        check("rst_fetch", fetch_instr, 32'h0);

        // 1: basic load, fetch_addr held at 0 during the write of entry 0
        foreach (prog1[i]) send(prog1[i], 0);
        check("t1_load_done", 32'(load_done), 32'd1);
        check("t1_core_rst", 32'(core_rst), 32'd0);
        check("t1_word_count", 32'(word_count), 32'd2);
        check("t1_model_mem0", m_mem[0], 32'h00500513);
        fetch(32'h0);
        check("t1_fetch0", fetch_instr, 32'h00500513);
        fetch(32'h4);
        check("t1_fetch4", fetch_instr, 32'h0);

        // 2: same stream with 3-cycle gaps
        fetch_addr = 32'h0;
        do_reset();
        foreach (prog1[i]) send(prog1[i], 3);
        check("t2_word_count", 32'(word_count), 32'd2);
        fetch(32'h0);
        check("t2_fetch0", fetch_instr, 32'h00500513);
        fetch(32'h4);
        check("t2_fetch4", fetch_instr, 32'h0);
        fetch(32'h8);
        check("t2_fetch8", fetch_instr, 32'h0);

        // 3: overflow without terminator
        do_reset();
        for (int w = 0; w < 32; w++) begin
            send(8'h13, 0); send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
        end
        check("t3_overflow", 32'(overflow_err), 32'd1);
        check("t3_core_rst", 32'(core_rst), 32'd1);
        check("t3_load_done", 32'(load_done), 32'd0);
        check("t3_word_count", 32'(word_count), 32'd32);
        check("t3_in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 4; i++) send(8'h00, 0);
        check("t3_count_hold", 32'(word_count), 32'd32);
        fetch(32'd124);
        check("t3_fetch_last", fetch_instr, 32'h00000013);

        // 4: reset mid-word
        fetch_addr = 32'h0;
        do_reset();
        send(8'hAA, 0); send(8'hBB, 0);
        do_reset();
        send(8'h33, 0); send(8'h02, 0); send(8'h00, 0); send(8'h00, 0);
        for (int i = 0; i < 4; i++) send(8'h00, 0);
        check("t4_word_count", 32'(word_count), 32'd2);
        check("t4_load_done", 32'(load_done), 32'd1);
        fetch(32'h0);
        check("t4_fetch0", fetch_instr, 32'h00000233);

        // 5: out-of-range and misaligned fetch
        fetch(32'h80);
        check("t5_oob", fetch_instr, 32'h0);
        fetch(32'h02);
        check("t5_misaligned", fetch_instr, 32'h00000233);
        fetch(32'hFFFF_FFFC);
        check("t5_oob_high", fetch_instr, 32'h0);

        // 6: bytes after DONE are ignored
        in_valid = 1'b1;
        in_byte  = 8'hFF;
        repeat (10) begin
            @(posedge clk); #1;
            check("t6_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        check("t6_word_count", 32'(word_count), 32'd2);
        check("t6_load_done", 32'(load_done), 32'd1);
        fetch(32'h0);
        check("t6_fetch0", fetch_instr, 32'h00000233);
        fetch(32'h4);
        check("t6_fetch4", fetch_instr, 32'h0);
        fetch(32'h8);
        check("t6_fetch8", fetch_instr, 32'h0);

        @(negedge clk);
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
